// File: rtl/conv_pass_sched_if.sv
// Bundle of layer-control, weight-ROM, convCal and result-RAM signals around the pass scheduler.
// The master modport is the scheduler side; slave is the surrounding datapath/controller.
interface conv_pass_sched_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int OUTPUT_CHANNEL = 8,
    parameter int OC_PER_PASS    = 2,
    parameter int RESULT_LENGTH  = 2,
    parameter int RESULT_WIDTH   = 2
);
    localparam int NUM_PASSES = OUTPUT_CHANNEL / OC_PER_PASS;
    localparam int PW         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int RW         = OC_PER_PASS * RESULT_LENGTH * RESULT_WIDTH * DATA_WIDTH;

    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          error;
    logic          wt_rd_en;
    logic [PW-1:0] wt_rd_addr;
    logic          conv_en;
    logic          cc_valid;
    logic [RW-1:0] cc_result;
    logic          res_wr_en;
    logic [PW-1:0] res_wr_addr;
    logic [RW-1:0] res_wr_data;

    modport master (
        input  start, abort, cc_valid, cc_result,
        output busy, done, error, wt_rd_en, wt_rd_addr, conv_en,
               res_wr_en, res_wr_addr, res_wr_data
    );

    modport slave (
        output start, abort, cc_valid, cc_result,
        input  busy, done, error, wt_rd_en, wt_rd_addr, conv_en,
               res_wr_en, res_wr_addr, res_wr_data
    );
endinterface

// File: rtl/conv_pass_sched.sv
// Time-multiplexes one convCal across all output channels of a conv layer, one pass at a time:
// load weight slice, run convCal until valid (or timeout), write the result slice.
module conv_pass_sched #(
    parameter int DATA_WIDTH     = 16,
    parameter int OUTPUT_CHANNEL = 8,
    parameter int OC_PER_PASS    = 2,
    parameter int RESULT_LENGTH  = 2,
    parameter int RESULT_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                clk,
    input logic                reset,
    conv_pass_sched_if.master  bus
);
    localparam int NUM_PASSES = OUTPUT_CHANNEL / OC_PER_PASS;
    localparam int PW         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int NUM_ELEMS  = OC_PER_PASS * RESULT_LENGTH * RESULT_WIDTH;
    localparam int TW         = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]    r_state;
    logic [PW-1:0] r_pass;
    logic [TW-1:0] r_tmo;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_wt_rd_en;
    logic [PW-1:0] r_wt_rd_addr;
    logic          r_conv_en;
    logic          r_res_wr_en;
    logic [PW-1:0] r_res_wr_addr;

    // Abort pre-empts a capture that would otherwise land in the same cycle.
    logic w_abort_active;
    logic w_capture;
    assign w_abort_active = (r_state != S_IDLE) && bus.abort;
    assign w_capture      = (r_state == S_RUN) && bus.cc_valid && !w_abort_active;

    // Output registers are loaded with the values of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pass        <= '0;
            r_tmo         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_wt_rd_en    <= 1'b0;
            r_wt_rd_addr  <= '0;
            r_conv_en     <= 1'b0;
            r_res_wr_en   <= 1'b0;
            r_res_wr_addr <= '0;
        end else begin
            r_done      <= 1'b0;
            r_wt_rd_en  <= 1'b0;
            r_conv_en   <= 1'b0;
            r_res_wr_en <= 1'b0;
            if (w_abort_active) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_tmo   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state      <= S_LOAD;
                            r_busy       <= 1'b1;
                            r_error      <= 1'b0;
                            r_pass       <= '0;
                            r_wt_rd_en   <= 1'b1;
                            r_wt_rd_addr <= '0;
                        end
                    end
                    S_LOAD: begin
                        r_state   <= S_RUN;
                        r_conv_en <= 1'b1;
                    end
                    S_RUN: begin
                        if (bus.cc_valid) begin
                            r_state       <= S_WRITE;
                            r_tmo         <= '0;
                            r_res_wr_en   <= 1'b1;
                            r_res_wr_addr <= r_pass;
                        end else if (r_tmo == TMO_LAST) begin
                            r_state <= S_ERR;
                            r_tmo   <= '0;
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_tmo     <= r_tmo + TW'(1);
                            r_conv_en <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (r_pass == LAST_PASS) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_LOAD;
                            r_pass       <= r_pass + PW'(1);
                            r_wt_rd_en   <= 1'b1;
                            r_wt_rd_addr <= r_pass + PW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Result capture, one register per float16 element of the slice.
    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_res_elem
            logic [DATA_WIDTH-1:0] r_elem;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_elem <= '0;
                end else if (w_capture) begin
                    r_elem <= bus.cc_result[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            assign bus.res_wr_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_elem;
        end
    endgenerate

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.wt_rd_en    = r_wt_rd_en;
    assign bus.wt_rd_addr  = r_wt_rd_addr;
    assign bus.conv_en     = r_conv_en;
    assign bus.res_wr_en   = r_res_wr_en;
    assign bus.res_wr_addr = r_res_wr_addr;
endmodule

// File: tb/tb_conv_pass_sched.sv
// Directed bench for conv_pass_sched with a latency-programmable convCal stub.
module tb_conv_pass_sched;
    localparam int DW  = 16;
    localparam int OC  = 8;
    localparam int OPP = 2;
    localparam int RL  = 2;
    localparam int RWD = 2;
    localparam int TO  = 64;
    localparam int NP  = OC / OPP;
    localparam int RW  = OPP * RL * RWD * DW;

    localparam logic [RW-1:0] DATA_18   = {8{16'h4C80}};
    localparam logic [RW-1:0] DATA_36   = {8{16'h5080}};
    localparam logic [RW-1:0] DATA_SPUR = {8{16'hDEAD}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_pass_sched_if #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(OC), .OC_PER_PASS(OPP),
                         .RESULT_LENGTH(RL), .RESULT_WIDTH(RWD)) bus ();

    conv_pass_sched #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(OC), .OC_PER_PASS(OPP),
                      .RESULT_LENGTH(RL), .RESULT_WIDTH(RWD), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // convCal stub: valid on the lat-th consecutive conv_en cycle, except on block_pass
    int            lat        = 5;
    int            block_pass = -1;
    logic [RW-1:0] mdata      = DATA_18;
    logic          spur       = 1'b0;
    int            mcnt       = 0;

    always @(posedge clk) mcnt <= bus.conv_en ? mcnt + 1 : 0;

    assign bus.cc_valid  = spur | (bus.conv_en && (mcnt == lat - 1) &&
                                   (int'(bus.wt_rd_addr) != block_pass));
    assign bus.cc_result = spur ? DATA_SPUR : mdata;

    int            cyc = 0;
    int            rd_q[$];
    int            rd_cyc_q[$];
    int            wa_q[$];
    int            wc_q[$];
    logic [RW-1:0] wd_q[$];
    int            idle_cnt = 0;
    int            done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wt_rd_en) begin
            rd_q.push_back(int'(bus.wt_rd_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (bus.res_wr_en) begin
            wa_q.push_back(int'(bus.res_wr_addr));
            wc_q.push_back(cyc);
            wd_q.push_back(bus.res_wr_data);
        end
        if (!bus.busy) idle_cnt++;
        if (bus.done) done_cnt++;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Step point: 2 time units after the rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        rd_cyc_q.delete();
        wa_q.delete();
        wc_q.delete();
        wd_q.delete();
        idle_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_layer();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok, output int dcyc, output logic derr);
        ok   = 1'b0;
        dcyc = 0;
        derr = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (bus.done) begin
                ok   = 1'b1;
                dcyc = cyc;
                derr = bus.error;
                return;
            end
        end
    endtask

    task automatic check_layer(input string tag, input logic [RW-1:0] data, input int span, input int dcyc);
        chk({tag, "_nrd"}, RW'(rd_q.size()), RW'(NP));
        chk({tag, "_nwr"}, RW'(wa_q.size()), RW'(NP));
        if (rd_q.size() == NP && wa_q.size() == NP) begin
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("%s_rdaddr%0d", tag, i), RW'(rd_q[i]), RW'(i));
                chk($sformatf("%s_wraddr%0d", tag, i), RW'(wa_q[i]), RW'(i));
                chk($sformatf("%s_wrdata%0d", tag, i), wd_q[i], data);
            end
            chk({tag, "_span"}, RW'(dcyc - rd_cyc_q[0]), RW'(span));
            chk({tag, "_done_after_wr"}, RW'(dcyc - wc_q[NP-1]), RW'(1));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        int            dcyc;
        logic          derr;
        logic [RW-1:0] held;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b1;
        repeat (3) step();
        chk("rst_busy", RW'(bus.busy), RW'(0));
        chk("rst_done", RW'(bus.done), RW'(0));
        chk("rst_error", RW'(bus.error), RW'(0));
        chk("rst_strobes", RW'({bus.wt_rd_en, bus.conv_en, bus.res_wr_en}), RW'(0));
        chk("rst_addrs", RW'({bus.wt_rd_addr, bus.res_wr_addr}), RW'(0));
        chk("rst_data", bus.res_wr_data, RW'(0));
        reset = 1'b0;
        step();

        // Normal layer: 4 x (1+5+1) + 1 cycles from first LOAD through done
        clear_logs();
        start_layer();
        chk("l1_load_en", RW'(bus.wt_rd_en), RW'(1));
        chk("l1_load_conv_en", RW'(bus.conv_en), RW'(0));
        wait_done(200, ok, dcyc, derr);
        chk("l1_done_seen", RW'(ok), RW'(1));
        chk("l1_error", RW'(derr), RW'(0));
        check_layer("l1", DATA_18, 28, dcyc);

        // Back-to-back layer with doubled image
        clear_logs();
        mdata = DATA_36;
        step();
        chk("b2b_idle_busy", RW'(bus.busy), RW'(0));
        chk("b2b_idle_done", RW'(bus.done), RW'(0));
        start_layer();
        wait_done(200, ok, dcyc, derr);
        chk("l2_done_seen", RW'(ok), RW'(1));
        check_layer("l2", DATA_36, 28, dcyc);
        chk("l2_idle_gap", RW'(idle_cnt), RW'(1));

        // Timeout on pass 1
        clear_logs();
        mdata      = DATA_18;
        block_pass = 1;
        step();
        start_layer();
        wait_done(400, ok, dcyc, derr);
        chk("to_done_seen", RW'(ok), RW'(1));
        chk("to_error_at_done", RW'(derr), RW'(1));
        chk("to_nwr", RW'(wa_q.size()), RW'(1));
        if (wa_q.size() > 0) chk("to_wraddr0", RW'(wa_q[0]), RW'(0));
        if (rd_cyc_q.size() > 1) chk("to_span", RW'(dcyc - rd_cyc_q[1]), RW'(65));
        block_pass = -1;
        repeat (5) step();
        chk("to_error_sticky", RW'(bus.error), RW'(1));
        chk("to_busy", RW'(bus.busy), RW'(0));

        // Abort in RUN of pass 2
        clear_logs();
        start_layer();
        chk("ab_error_cleared", RW'(bus.error), RW'(0));
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.conv_en && bus.wt_rd_addr == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ab_reach_pass2", RW'(ok), RW'(1));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab_busy", RW'(bus.busy), RW'(0));
        chk("ab_conv_en", RW'(bus.conv_en), RW'(0));
        chk("ab_done", RW'(bus.done), RW'(0));
        repeat (10) step();
        chk("ab_nwr", RW'(wa_q.size()), RW'(2));
        chk("ab_done_cnt", RW'(done_cnt), RW'(0));
        chk("ab_abort_idle_busy", RW'(bus.busy), RW'(0));
        clear_logs();
        start_layer();
        chk("ab_restart_addr", RW'(bus.wt_rd_addr), RW'(0));
        wait_done(200, ok, dcyc, derr);
        chk("ab_restart_done", RW'(ok), RW'(1));
        check_layer("ab_restart", DATA_18, 28, dcyc);

        // Reset during WRITE of pass 1
        step();
        clear_logs();
        mdata = DATA_36;
        start_layer();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.res_wr_en && bus.res_wr_addr == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rs_reach_write1", RW'(ok), RW'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rs_outputs", RW'({bus.busy, bus.done, bus.error, bus.wt_rd_en, bus.conv_en,
                               bus.res_wr_en, bus.wt_rd_addr, bus.res_wr_addr}), RW'(0));
        chk("rs_data", bus.res_wr_data, RW'(0));
        step();
        clear_logs();
        mdata = DATA_18;
        start_layer();
        chk("rs_restart_addr", RW'(bus.wt_rd_addr), RW'(0));
        wait_done(200, ok, dcyc, derr);
        chk("rs_restart_done", RW'(ok), RW'(1));
        check_layer("rs_restart", DATA_18, 28, dcyc);

        // Spurious cc_valid in IDLE and LOAD, start while busy
        step();
        held = bus.res_wr_data;
        clear_logs();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        chk("sp_idle_nocap", bus.res_wr_data, held);
        chk("sp_idle_busy", RW'(bus.busy), RW'(0));
        start_layer();
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(200, ok, dcyc, derr);
        chk("sp_done_seen", RW'(ok), RW'(1));
        check_layer("sp", DATA_18, 28, dcyc);
        repeat (4) step();
        chk("sp_no_restart", RW'(bus.busy), RW'(0));
        chk("sp_done_cnt", RW'(done_cnt), RW'(1));

        // cc_valid on the timeout-terminal cycle still writes
        clear_logs();
        lat = TO;
        start_layer();
        wait_done(400, ok, dcyc, derr);
        chk("tt_done_seen", RW'(ok), RW'(1));
        chk("tt_error", RW'(derr), RW'(0));
        check_layer("tt", DATA_18, 4 * (1 + TO + 1), dcyc);
        lat = 5;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/conv_pass_sched.md
Name: conv_pass_sched

Overview:
- Sequencer that shares one convCal instance across all output channels of a conv layer.
- A layer is split into NUM_PASSES = OUTPUT_CHANNEL/OC_PER_PASS passes. Each pass runs the same steps in order:
  - fetch the weight slice for that pass,
  - pulse conv_en through convCal,
  - wait for cc_valid,
  - write the result slice to the feature-map buffer.
- Sits between the layer-level controller (start/done) and the convCal, weight-ROM and result-RAM ports.

Parameters:
- DATA_WIDTH, 16, float16 element width.
- OUTPUT_CHANNEL, 8, total output channels in the layer.
- OC_PER_PASS, 2, output channels computed per convCal pass. OUTPUT_CHANNEL must be a multiple of it.
- RESULT_LENGTH, 2, result rows per channel.
- RESULT_WIDTH, 2, result columns per channel.
- TIMEOUT_CYCLES, 64, maximum RUN cycles allowed before error.
- Derived: NUM_PASSES = OUTPUT_CHANNEL/OC_PER_PASS; PW = max(1, clog2(NUM_PASSES)); RW = OC_PER_PASS*RESULT_LENGTH*RESULT_WIDTH*DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin layer; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current layer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at layer end (normal or error).
- error  out  1  sticky timeout flag.
- wt_rd_en  out  1  weight-slice read strobe.
- wt_rd_addr  out  PW  pass index for the weight read.
- conv_en  out  1  convCal enable.
- cc_valid  in  1  convCal result valid.
- cc_result  in  RW  convCal result bus.
- res_wr_en  out  1  result-buffer write strobe.
- res_wr_addr  out  PW  pass index for the result write.
- res_wr_data  out  RW  captured result.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high; wins over every other input):
  - state = IDLE, pass counter = 0, timeout counter = 0.
  - busy, done, error, wt_rd_en, conv_en, res_wr_en = 0.
  - wt_rd_addr, res_wr_addr, res_wr_data = 0.
- States and transitions:
  - IDLE:
    - start=1 → LOAD.
    - error cleared, pass counter cleared, busy=1 from the next cycle.
  - LOAD (1 cycle):
    - wt_rd_en=1, wt_rd_addr=pass, conv_en=0.
    - → RUN.
    - conv_en is always low in LOAD, so convCal restarts on every pass.
  - RUN:
    - conv_en=1; timeout counter increments each cycle.
    - cc_valid=1: capture cc_result into res_wr_data → WRITE.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 → ERR.
    - Timeout counter clears on leaving RUN.
  - WRITE (1 cycle):
    - res_wr_en=1, res_wr_addr=pass, conv_en=0.
    - If pass == NUM_PASSES-1 → FIN; else pass+1 → LOAD.
  - FIN (1 cycle): done=1 → IDLE.
  - ERR (1 cycle): error=1 (held until the next accepted start), done=1, conv_en=0 → IDLE.
- Latency:
  - start cycle → LOAD is 1 cycle.
  - Per pass: 1 (LOAD) + N (RUN cycles up to and including the cc_valid cycle) + 1 (WRITE).
  - done occurs 1 cycle after the last WRITE.
- Boundary conditions:
  - start while busy: ignored.
  - start in the same cycle as a FIN/ERR→IDLE transition: ignored.
  - cc_valid outside RUN: ignored, nothing captured.
  - cc_valid on the timeout-terminal cycle: cc_valid wins → WRITE, error stays 0.
  - abort=1 in any non-IDLE state → IDLE next cycle:
    - all strobes and conv_en = 0, done not pulsed, error unchanged.
    - A write that is in flight in the same cycle still completes, since outputs are registered.
  - abort in IDLE: no effect.
  - abort and start together in IDLE: start wins.
  - NUM_PASSES=1: LOAD→RUN→WRITE→FIN; addresses always 0.
  - Pass counter never wraps; it holds at NUM_PASSES-1 until cleared by the next start.

Test Plan:
- Normal layer, defaults (4 passes):
  - Stimulus: convCal model raises cc_valid 5 cycles after conv_en rises, returning 0x4C80 (18.0) in all 8 elements.
  - Required: wt_rd_addr 0,1,2,3 in order; res_wr_en pulses with addr 0..3 and data all 0x4C80; done one cycle after the last write; total 4×(1+5+1)+1 cycles from LOAD; error=0.
- Back-to-back layers:
  - Stimulus: start asserted the cycle after done, with the image stub changed to 2.0.
  - Required: the second layer writes 0x5080 (36.0) to addr 0..3; busy low exactly 1 cycle between layers.
- Timeout:
  - Stimulus: cc_valid never asserted on pass 1.
  - Required: ERR after 64 RUN cycles; done=1 and error=1 in the same cycle; no write to addr 1; error stays high until the next start.
- Abort:
  - Stimulus: abort during RUN of pass 2.
  - Required: IDLE next cycle; conv_en=0; no done; no write to addr 2 or 3; a fresh start restarts at addr 0.
- Reset mid-operation:
  - Stimulus: reset asserted during WRITE of pass 1.
  - Required: all outputs 0 next cycle; a subsequent start begins at wt_rd_addr 0.
- Spurious inputs:
  - Stimulus: cc_valid pulsed in IDLE and LOAD; start pulsed while busy.
  - Required: no capture, no extra writes, pass sequence unchanged.
